// File: rtl/iic_write_engine_if.sv
// ============================================================================
//  Module      : iic_write_engine_if
//  Description : Request/status bundle between the init-command sequencer
//                (master side) and the I2C write engine (slave side), plus
//                the push-pull SCL line driven by the engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface iic_write_engine_if #(
    parameter int REG_W = 16
);
    logic [15:0]      slave_addr;
    logic [REG_W-1:0] reg_addr;
    logic [7:0]       send_data;
    logic             send_en;
    logic             send_busy;
    logic             ack_err;
    logic             iic_scl;

    // Requester: presents one address/data pair and watches busy/error.
    modport master (
        output slave_addr, reg_addr, send_data, send_en,
        input  send_busy, ack_err, iic_scl
    );

    // Engine: consumes the request and drives status plus SCL.
    modport slave (
        input  slave_addr, reg_addr, send_data, send_en,
        output send_busy, ack_err, iic_scl
    );
endinterface

`default_nettype wire

// File: rtl/iic_write_engine.sv
// ============================================================================
//  Module      : iic_write_engine
//  Description : Write-only I2C master. One request produces START, slave
//                address (7- or 10-bit) with W, register address bytes, one
//                data byte and STOP. SCL push-pull, SDA open-drain.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iic_write_engine #(
    parameter int CLK_FRE           = 50,
    parameter int IIC_FRE           = 100,
    parameter int IIC_SLAVE_ADDR_EX = 0,
    parameter int IIC_SLAVE_REG_EX  = 1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    iic_write_engine_if.slave req_if,
    inout  wire               iic_sda
);
    localparam int QDIV_RAW = (CLK_FRE * 1000) / (IIC_FRE * 4);
    localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
    localparam int TW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int NB       = 1 + IIC_SLAVE_ADDR_EX + (IIC_SLAVE_REG_EX + 1) + 1;
    localparam int SW       = 8 * NB;
    localparam int BW       = $clog2(NB + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BYTE  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      quarter_q, quarter_d;
    logic [3:0]      bit_q, bit_d;
    logic [BW-1:0]   bytes_q, bytes_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic            busy_q, busy_d;
    logic            ack_err_q, ack_err_d;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;

    logic [SW-1:0]   w_load;
    logic            w_qend;
    logic            w_sda_in;
    logic            w_unused_addr;

    // Only the low 7 or 10 address bits are transmitted.
    assign w_unused_addr = ^req_if.slave_addr;

    generate
        if (IIC_SLAVE_ADDR_EX != 0) begin : g_addr10
            assign w_load = {5'b11110, req_if.slave_addr[9:8], 1'b0,
                             req_if.slave_addr[7:0], req_if.reg_addr, req_if.send_data};
        end else begin : g_addr7
            assign w_load = {req_if.slave_addr[6:0], 1'b0,
                             req_if.reg_addr, req_if.send_data};
        end
    endgenerate

    assign w_qend   = (tick_q == TW'(QDIV - 1));
    assign w_sda_in = iic_sda;

    // Sequencing: quarter ticks, phase/bit/byte advance, acceptance and NACK.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        quarter_d = quarter_q;
        bit_d     = bit_q;
        bytes_d   = bytes_q;
        shift_d   = shift_q;
        busy_d    = busy_q;
        ack_err_d = ack_err_q;
        if (state_q == S_IDLE) begin
            tick_d    = '0;
            quarter_d = 2'd0;
            bit_d     = 4'd0;
            if (req_if.send_en) begin
                state_d   = S_START;
                busy_d    = 1'b1;
                ack_err_d = 1'b0;
                shift_d   = w_load;
                bytes_d   = BW'(NB);
            end
        end else begin
            tick_d = w_qend ? '0 : tick_q + 1'b1;
            // ACK bit: the slave's answer is taken on the last clock of q1.
            if (state_q == S_BYTE && bit_q == 4'd8 && quarter_q == 2'd1 && w_qend && w_sda_in)
                ack_err_d = 1'b1;
            if (w_qend) begin
                quarter_d = quarter_q + 2'd1;
                if (quarter_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_BYTE;
                            bit_d   = 4'd0;
                        end
                        S_BYTE: begin
                            if (bit_q != 4'd8) begin
                                bit_d   = bit_q + 4'd1;
                                shift_d = shift_q << 1;
                            end else begin
                                bit_d   = 4'd0;
                                bytes_d = bytes_q - 1'b1;
                                // A NACK abandons the remaining bytes.
                                if (ack_err_q || bytes_q == BW'(1))
                                    state_d = S_STOP;
                            end
                        end
                        S_STOP: begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Line levels for the phase being entered, so SCL/SDA come from flops.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d    = ~quarter_d[1];
                sda_oe_d = (quarter_d != 2'd0);
            end
            S_BYTE: begin
                scl_d    = (quarter_d == 2'd1) || (quarter_d == 2'd2);
                sda_oe_d = (bit_d != 4'd8) && !shift_d[SW-1];
            end
            S_STOP: begin
                scl_d    = (quarter_d != 2'd0);
                sda_oe_d = ~quarter_d[1];
            end
            default: ;
        endcase
    end

    // State and output registers; reset aborts any transfer without a STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            quarter_q <= 2'd0;
            bit_q     <= 4'd0;
            bytes_q   <= '0;
            shift_q   <= '0;
            busy_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            quarter_q <= quarter_d;
            bit_q     <= bit_d;
            bytes_q   <= bytes_d;
            shift_q   <= shift_d;
            busy_q    <= busy_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign iic_sda          = sda_oe_q ? 1'b0 : 1'bz;
    assign req_if.iic_scl   = scl_q;
    assign req_if.send_busy = busy_q;
    assign req_if.ack_err   = ack_err_q;

endmodule

`default_nettype wire

// File: tb/tb_iic_write_engine.sv
// ============================================================================
//  Module      : tb_iic_write_engine
//  Description : Directed bench for iic_write_engine in three configurations
//                (7-bit/8-bit reg, 7-bit/16-bit reg, 10-bit/8-bit reg) with
//                an I2C slave model, bus byte decoder and byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iic_write_engine;
    localparam int QDIV = (8 * 1000) / (1000 * 4);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] t_slave = '0;
    logic [15:0] t_reg = '0;
    logic [7:0]  t_data = '0;
    logic        t_en = 1'b0;
    int          sel = 0;
    int          nack_byte = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    iic_write_engine_if #(.REG_W(8))  if_a ();
    iic_write_engine_if #(.REG_W(16)) if_b ();
    iic_write_engine_if #(.REG_W(8))  if_c ();

    wire sda_a;
    wire sda_b;
    wire sda_c;
    pullup (sda_a);
    pullup (sda_b);
    pullup (sda_c);

    logic ack_drv = 1'b0;
    assign sda_a = (ack_drv && sel == 0) ? 1'b0 : 1'bz;
    assign sda_b = (ack_drv && sel == 1) ? 1'b0 : 1'bz;
    assign sda_c = (ack_drv && sel == 2) ? 1'b0 : 1'bz;

    assign if_a.slave_addr = t_slave;
    assign if_a.reg_addr   = t_reg[7:0];
    assign if_a.send_data  = t_data;
    assign if_a.send_en    = t_en && (sel == 0);
    assign if_b.slave_addr = t_slave;
    assign if_b.reg_addr   = t_reg;
    assign if_b.send_data  = t_data;
    assign if_b.send_en    = t_en && (sel == 1);
    assign if_c.slave_addr = t_slave;
    assign if_c.reg_addr   = t_reg[7:0];
    assign if_c.send_data  = t_data;
    assign if_c.send_en    = t_en && (sel == 2);

    iic_write_engine #(.CLK_FRE(8), .IIC_FRE(1000), .IIC_SLAVE_ADDR_EX(0), .IIC_SLAVE_REG_EX(0))
        dut_a (.clk(clk), .rst(rst), .req_if(if_a), .iic_sda(sda_a));
    iic_write_engine #(.CLK_FRE(8), .IIC_FRE(1000), .IIC_SLAVE_ADDR_EX(0), .IIC_SLAVE_REG_EX(1))
        dut_b (.clk(clk), .rst(rst), .req_if(if_b), .iic_sda(sda_b));
    iic_write_engine #(.CLK_FRE(8), .IIC_FRE(1000), .IIC_SLAVE_ADDR_EX(1), .IIC_SLAVE_REG_EX(0))
        dut_c (.clk(clk), .rst(rst), .req_if(if_c), .iic_sda(sda_c));

    wire mon_scl  = (sel == 0) ? if_a.iic_scl   : (sel == 1) ? if_b.iic_scl   : if_c.iic_scl;
    wire mon_sda  = (sel == 0) ? sda_a          : (sel == 1) ? sda_b          : sda_c;
    wire mon_busy = (sel == 0) ? if_a.send_busy : (sel == 1) ? if_b.send_busy : if_c.send_busy;
    wire mon_err  = (sel == 0) ? if_a.ack_err   : (sel == 1) ? if_b.ack_err   : if_c.ack_err;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];

    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_busy = 1'b0;
    logic [7:0] shreg = '0;
    int         bit_cnt = 0;
    int         byte_idx = 0;
    int         busy_cnt = 0;
    int         start_cnt = 0;
    int         stop_cnt = 0;

    // Bus decoder and slave: bytes on SCL rises, START/STOP edges, ACK drive.
    always @(negedge clk) begin
        prev_scl  <= mon_scl;
        prev_sda  <= mon_sda;
        prev_busy <= mon_busy;
        if (rst) begin
            bit_cnt  <= 0;
            byte_idx <= 0;
            ack_drv  <= 1'b0;
        end else begin
            if (mon_busy) busy_cnt <= busy_cnt + 1;
            if (mon_busy && !prev_busy) start_cnt <= start_cnt + 1;
            if (prev_scl && mon_scl && prev_sda && !mon_sda) begin
                bit_cnt  <= 0;
                byte_idx <= 0;
            end
            if (prev_scl && mon_scl && !prev_sda && mon_sda) stop_cnt <= stop_cnt + 1;
            if (!prev_scl && mon_scl) begin
                if (bit_cnt == 8) begin
                    bit_cnt  <= 0;
                    byte_idx <= byte_idx + 1;
                end else begin
                    shreg   <= {shreg[6:0], mon_sda};
                    bit_cnt <= bit_cnt + 1;
                    if (bit_cnt == 7) obs_q.push_back({shreg[6:0], mon_sda});
                end
            end
            if (prev_scl && !mon_scl)
                ack_drv <= (bit_cnt == 8) && (byte_idx + 1 != nack_byte);
        end
    end

    function automatic int exp_busy(int k);
        return (4 + 36 * k + 4) * QDIV;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_sb(string tag);
        check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_done(string tag);
        int n;
        n = 0;
        while (mon_busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, mon_busy, 0);
    endtask

    // Called at a negedge with the selected engine idle.
    task automatic run_txn(string tag, int k, logic exp_err, bit pulse_mid);
        int b0, s0, st0;
        b0  = busy_cnt;
        s0  = start_cnt;
        st0 = stop_cnt;
        t_en = 1'b1;
        @(negedge clk);
        t_en = 1'b0;
        check({tag, "_busy_rise"}, mon_busy, 1);
        check({tag, "_err_clr"}, mon_err, 0);
        if (pulse_mid) begin
            repeat (40) @(negedge clk);
            t_en = 1'b1;
            @(negedge clk);
            t_en = 1'b0;
        end
        wait_done(tag);
        check({tag, "_busy_len"}, busy_cnt - b0, exp_busy(k));
        check({tag, "_ack_err"}, mon_err, exp_err);
        repeat (20) @(negedge clk);
        check({tag, "_starts"}, start_cnt - s0, 1);
        check({tag, "_stops"}, stop_cnt - st0, 1);
        check({tag, "_err_sticky"}, mon_err, exp_err);
        compare_sb(tag);
    endtask

    initial begin
        int b0, s0, st0, gap;
        repeat (3) @(negedge clk);
        // Reset state on every configuration.
        for (int i = 0; i < 3; i++) begin
            sel = i;
            #1;
            check("rst_busy", mon_busy, 0);
            check("rst_err", mon_err, 0);
            check("rst_scl", mon_scl, 1);
            check("rst_sda", mon_sda, 1);
        end
        @(negedge clk);
        rst = 1'b0;
        sel = 0;
        repeat (2) @(negedge clk);

        // 7-bit, 8-bit register, slave ACKs everything.
        t_slave = 16'h003C; t_reg = 16'h0012; t_data = 8'hA5; nack_byte = 0;
        exp_q.push_back(8'h78); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
        run_txn("ack7", 3, 1'b0, 1'b0);

        // Address byte NACKed: STOP right after byte 1.
        nack_byte = 1;
        exp_q.push_back(8'h78);
        run_txn("nack1", 1, 1'b1, 1'b0);

        // Next request clears the error; a pulse during busy is ignored.
        nack_byte = 0;
        exp_q.push_back(8'h78); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
        run_txn("clr", 3, 1'b0, 1'b1);

        // Register byte NACKed.
        nack_byte = 2;
        exp_q.push_back(8'h78); exp_q.push_back(8'h12);
        run_txn("nack2", 2, 1'b1, 1'b0);
        nack_byte = 0;

        // 16-bit register address, MSB byte first.
        sel = 1;
        t_reg = 16'hBEEF; t_data = 8'h01;
        @(negedge clk);
        exp_q.push_back(8'h78); exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF); exp_q.push_back(8'h01);
        run_txn("reg16", 4, 1'b0, 1'b0);

        // 10-bit slave address.
        sel = 2;
        t_slave = 16'h02B5; t_reg = 16'h0012; t_data = 8'h5A;
        @(negedge clk);
        exp_q.push_back(8'hF4); exp_q.push_back(8'hB5);
        exp_q.push_back(8'h12); exp_q.push_back(8'h5A);
        run_txn("addr10", 4, 1'b0, 1'b0);

        // send_en held high: back-to-back transfers separated by one idle clock.
        sel = 0;
        t_slave = 16'h003C; t_reg = 16'h0012; t_data = 8'hA5;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(8'h78); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
        end
        b0 = busy_cnt; s0 = start_cnt; st0 = stop_cnt;
        t_en = 1'b1;
        @(negedge clk);
        check("held_busy_rise", mon_busy, 1);
        wait_done("held_1");
        gap = 1;
        while (mon_busy !== 1'b1 && gap < 10) begin
            @(negedge clk);
            if (mon_busy !== 1'b1) gap++;
        end
        check("held_idle_gap", gap, 1);
        t_en = 1'b0;
        wait_done("held_2");
        repeat (20) @(negedge clk);
        check("held_busy_len", busy_cnt - b0, 2 * exp_busy(3));
        check("held_starts", start_cnt - s0, 2);
        check("held_stops", stop_cnt - st0, 2);
        compare_sb("held");

        // Reset in the middle of the data byte.
        t_en = 1'b1;
        @(negedge clk);
        t_en = 1'b0;
        repeat (180) @(negedge clk);
        check("mid_bytes_done", obs_q.size(), 2);
        check("mid_busy", mon_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_scl", mon_scl, 1);
        check("abort_sda", mon_sda, 1);
        check("abort_busy", mon_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h78); exp_q.push_back(8'h12); exp_q.push_back(8'hA5);
        run_txn("post_rst", 3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

`default_nettype wire
